locked_register_access_arbiter: RTL

Shares a bank of sticky-lockable configuration registers between several bus requesters. It runs a round-robin arbitration and a three-state access FSM, and enforces a per-register write lock. A trusted requester in debug mode may override the lock. The block sits between the requester ports and the register bank and replaces per-register ad-hoc write gating with one checked access path.

---
 rtl/locked_reg_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/locked_register_access_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/locked_reg_pkg.sv
// rtl/locked_reg_pkg.sv - shared types and helpers for the locked register access arbiter
// Purpose: access FSM state encoding, default register width and the
// address range check used when NUM_REGS is not a power of two.
package locked_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int DEFAULT_DATA_W = 16;

  // Index width is rounded up, so indices at or above num_regs can be
  // presented on the bus and must be rejected.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner select
// Purpose: picks the first set request at or after ptr_i, wrapping around.
// Ports:
//   req_i   - request vector
//   ptr_i   - requester index where the search starts
//   gnt_o   - one-hot winner (zero when no request)
//   idx_o   - index of the winner
//   valid_o - at least one request present
module rr_arbiter
  import locked_reg_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               valid_o
);

  always_comb begin
    int   cand;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = ID_W'(cand);
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/locked_register_access_arbiter.sv
// rtl/locked_register_access_arbiter.sv - round-robin access path to a bank of sticky-lockable registers
// Purpose: serves one requester at a time through IDLE -> CHECK -> RESP,
// writing the register bank only when the target is unlocked or the
// winner is trusted while debug_mode_i is set.
// Ports:
//   clk_i, reset_i   - clock, asynchronous active-high reset
//   req_i            - per-requester request, held until gnt_o
//   req_addr_i       - flattened register index per requester
//   req_data_i       - flattened write data per requester
//   req_lock_i       - lock the target after a successful write
//   trusted_i        - per-requester trust flag
//   debug_mode_i     - global debug enable (sampled in CHECK)
//   gnt_o            - one-hot, one-cycle grant
//   resp_valid_o     - response strobe, coincident with gnt_o
//   resp_err_o       - access denied, qualified by resp_valid_o
//   resp_id_o        - index of the granted requester
//   lock_status_o    - sticky lock bits
//   reg_data_o       - flattened register contents
module locked_register_access_arbiter
  import locked_reg_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int NUM_REGS = 8,
  parameter  int DATA_W   = DEFAULT_DATA_W,
  localparam int ADDR_W   = $clog2(NUM_REGS),
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]         req_lock_i,
  input  logic [NUM_REQ-1:0]         trusted_i,
  input  logic                       debug_mode_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       resp_valid_o,
  output logic                       resp_err_o,
  output logic [ID_W-1:0]            resp_id_o,
  output logic [NUM_REGS-1:0]        lock_status_o,
  output logic [NUM_REGS*DATA_W-1:0] reg_data_o
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic [ID_W-1:0]      win_q, win_d;
  logic [NUM_REQ-1:0]   win_oh_q, win_oh_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 lkreq_q, lkreq_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]  locks_q;
  logic                 wr_en;
  logic                 set_lock;
  logic                 in_range;
  logic                 tgt_locked;
  logic                 allowed;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i   (req_i),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    win_d      = win_q;
    win_oh_d   = win_oh_q;
    addr_d     = addr_q;
    data_d     = data_q;
    lkreq_d    = lkreq_q;
    gnt_d      = '0;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    id_d       = id_q;
    wr_en      = 1'b0;
    set_lock   = 1'b0;
    in_range   = 1'b0;
    tgt_locked = 1'b0;
    allowed    = 1'b0;

    case (state_q)
      IDLE: begin
        // Latch everything now so an early drop of req still completes.
        if (arb_valid) begin
          win_d    = arb_idx;
          win_oh_d = arb_gnt;
          addr_d   = req_addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];
          data_d   = req_data_i[int'(arb_idx)*DATA_W +: DATA_W];
          lkreq_d  = req_lock_i[arb_idx];
          state_d  = CHECK;
        end
      end
      CHECK: begin
        // debug_mode_i and trusted_i are taken live here, not at latch time.
        in_range   = addr_in_range(32'(addr_q), NUM_REGS);
        tgt_locked = in_range && locks_q[addr_q];
        allowed    = in_range && (!tgt_locked || (debug_mode_i && trusted_i[win_q]));
        wr_en      = allowed;
        set_lock   = allowed && lkreq_q;
        // Response registers load here so they are high during RESP.
        gnt_d      = win_oh_q;
        valid_d    = 1'b1;
        err_d      = !allowed;
        id_d       = win_q;
        state_d    = RESP;
      end
      RESP: begin
        rr_d    = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      win_q    <= '0;
      win_oh_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      lkreq_q  <= 1'b0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      id_q     <= '0;
      locks_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      win_q    <= win_d;
      win_oh_q <= win_oh_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      lkreq_q  <= lkreq_d;
      gnt_q    <= gnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      id_q     <= id_d;
      if (wr_en) begin
        regs_q[addr_q] <= data_q;
      end
      // Locks only ever set; a debug override never clears one.
      if (set_lock) begin
        locks_q[addr_q] <= 1'b1;
      end
    end
  end

  assign gnt_o         = gnt_q;
  assign resp_valid_o  = valid_q;
  assign resp_err_o    = err_q;
  assign resp_id_o     = id_q;
  assign lock_status_o = locks_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_data_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule
